// File: rtl/twiddle_stream_gen_pkg.sv
// Shared FFT-stage definitions: stage state encoding, control state and the
// elaboration-time fixed-point trig helper used to build twiddle tables.
package fft_pkg;

  typedef enum logic [1:0] {
    ST_FILL = 2'd0,
    ST_PASS = 2'd1,
    ST_TWID = 2'd2
  } stage_state_t;

  typedef enum logic {
    CTRL_RUN   = 1'b0,
    CTRL_DRAIN = 1'b1
  } ctrl_state_t;

  localparam real TWO_PI = 6.283185307179586;

  // round(cos|sin(2*pi*num/den) * 2^frac_w), half away from zero; Taylor series
  // keeps this a plain constant function (angle stays in [0, pi) for callers).
  function automatic integer round_trig(input integer num, input integer den,
                                        input integer frac_w, input bit want_sin);
    real x;
    real term;
    real acc;
    real scale;
    real scaled;
    x = TWO_PI * $itor(num) / $itor(den);
    if (want_sin) begin
      term = x;
      acc  = x;
      for (int i = 1; i < 24; i++) begin
        term = -term * x * x / $itor((2 * i) * (2 * i + 1));
        acc  = acc + term;
      end
    end else begin
      term = 1.0;
      acc  = 1.0;
      for (int i = 1; i < 24; i++) begin
        term = -term * x * x / $itor((2 * i - 1) * (2 * i));
        acc  = acc + term;
      end
    end
    scale = 1.0;
    for (int j = 0; j < frac_w; j++) begin
      scale = scale * 2.0;
    end
    scaled = acc * scale;
    if (scaled >= 0.0) begin
      return $rtoi(scaled + 0.5);
    end else begin
      return -$rtoi(0.5 - scaled);
    end
  endfunction

endpackage

// File: rtl/twiddle_stream_gen_if.sv
// Sample-stream handshake and twiddle/state output bundle of one SDF stage.
interface twiddle_stream_gen_if #(
  parameter int DATA_W = 24
) ();

  logic                     in_valid;
  logic                     in_last;
  logic                     inv;
  logic                     in_ready;
  logic                     out_valid;
  logic                     out_last;
  logic signed [DATA_W-1:0] w_r;
  logic signed [DATA_W-1:0] w_i;
  logic [1:0]               state;

  modport master (
    output in_valid, in_last, inv,
    input  in_ready, out_valid, out_last, w_r, w_i, state
  );

  modport slave (
    input  in_valid, in_last, inv,
    output in_ready, out_valid, out_last, w_r, w_i, state
  );

endinterface

// File: rtl/twiddle_stream_gen_twiddle_table.sv
// Combinational twiddle lookup for TWID index k; entries are generated at
// elaboration, w_i stores -sin so forward mode needs no negation.
module twiddle_table
  import fft_pkg::*;
#(
  parameter int DATA_W = 24,
  parameter int FRAC_W = 8,
  parameter int N_FFT  = 16,
  parameter int HALF   = 8,
  localparam int KW    = (HALF > 1) ? $clog2(HALF) : 1
) (
  input  logic [KW-1:0]            k,
  input  logic                     inv,
  output logic signed [DATA_W-1:0] w_r,
  output logic signed [DATA_W-1:0] w_i
);

  localparam int STRIDE = N_FFT / (2 * HALF);

  logic signed [DATA_W-1:0] cos_tab_s  [HALF];
  logic signed [DATA_W-1:0] nsin_tab_s [HALF];

  for (genvar g = 0; g < HALF; g++) begin : g_tab
    assign cos_tab_s[g]  = DATA_W'(round_trig(g * STRIDE, N_FFT, FRAC_W, 1'b0));
    assign nsin_tab_s[g] = DATA_W'(-round_trig(g * STRIDE, N_FFT, FRAC_W, 1'b1));
  end

  // Table read with conjugation for the inverse transform.
  always_comb begin
    w_r = {DATA_W{1'b0}};
    w_i = {DATA_W{1'b0}};
    if (int'(k) < HALF) begin
      w_r = cos_tab_s[k];
      if (inv) begin
        w_i = -nsin_tab_s[k];
      end else begin
        w_i = nsin_tab_s[k];
      end
    end else begin
      w_r = {DATA_W{1'b0}};
      w_i = {DATA_W{1'b0}};
    end
  end

endmodule

// File: rtl/twiddle_stream_gen.sv
// Radix-2 SDF stage twiddle sequencer: fill/pass/twiddle counters, frame drain
// and registered twiddle + state outputs, one cycle behind the stepped sample.
module twiddle_stream_gen
  import fft_pkg::*;
#(
  parameter int DATA_W = 24,
  parameter int FRAC_W = 8,
  parameter int N_FFT  = 16,
  parameter int HALF   = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  twiddle_stream_gen_if.slave  bus
);

  localparam int STRIDE = N_FFT / (2 * HALF);
  localparam int PW     = $clog2(2 * HALF);
  localparam int FW     = $clog2(HALF + 1);
  localparam int KW     = (HALF > 1) ? $clog2(HALF) : 1;

  localparam logic [FW-1:0] HALF_F   = FW'(HALF);
  localparam logic [PW-1:0] HALF_P   = PW'(HALF);
  localparam logic [KW-1:0] DRAIN_LAST = KW'(HALF - 1);
  localparam logic signed [DATA_W-1:0] W_ONE =
    {{(DATA_W-1){1'b0}}, 1'b1} << FRAC_W;

  ctrl_state_t  ctrl_r;
  ctrl_state_t  ctrl_nxt_s;
  logic [FW-1:0] fill_cnt_r;
  logic [PW-1:0] p_r;
  logic [KW-1:0] drain_cnt_r;
  logic          inv_q_r;

  logic          in_ready_s;
  logic          draining_s;
  logic          step_s;
  logic          last_drain_s;
  stage_state_t  cur_state_s;
  logic [KW-1:0] k_s;
  logic signed [DATA_W-1:0] tw_r_s;
  logic signed [DATA_W-1:0] tw_i_s;

  logic          out_valid_r;
  logic          out_last_r;
  logic signed [DATA_W-1:0] w_r_r;
  logic signed [DATA_W-1:0] w_i_r;
  stage_state_t  state_r;

  // Control state register: RUN accepts samples, DRAIN self-steps HALF times.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ctrl_r <= CTRL_RUN;
    end else begin
      ctrl_r <= ctrl_nxt_s;
    end
  end

  // Next control state.
  always_comb begin
    ctrl_nxt_s = ctrl_r;
    case (ctrl_r)
      CTRL_RUN: begin
        if (bus.in_valid & in_ready_s & bus.in_last) begin
          ctrl_nxt_s = CTRL_DRAIN;
        end else begin
          ctrl_nxt_s = CTRL_RUN;
        end
      end
      CTRL_DRAIN: begin
        if (last_drain_s) begin
          ctrl_nxt_s = CTRL_RUN;
        end else begin
          ctrl_nxt_s = CTRL_DRAIN;
        end
      end
      default: ctrl_nxt_s = CTRL_RUN;
    endcase
  end

  // Control outputs decoded from the registered control state.
  always_comb begin
    in_ready_s = 1'b1;
    draining_s = 1'b0;
    case (ctrl_r)
      CTRL_RUN: begin
        in_ready_s = 1'b1;
        draining_s = 1'b0;
      end
      CTRL_DRAIN: begin
        in_ready_s = 1'b0;
        draining_s = 1'b1;
      end
      default: begin
        in_ready_s = 1'b1;
        draining_s = 1'b0;
      end
    endcase
  end

  // Stage position of the sample being stepped this cycle.
  always_comb begin
    step_s       = (bus.in_valid & in_ready_s) | draining_s;
    last_drain_s = draining_s & (drain_cnt_r == DRAIN_LAST);
    k_s          = KW'(p_r - HALF_P);
    if (fill_cnt_r < HALF_F) begin
      cur_state_s = ST_FILL;
    end else if (p_r < HALF_P) begin
      cur_state_s = ST_PASS;
    end else begin
      cur_state_s = ST_TWID;
    end
  end

  twiddle_table #(
    .DATA_W (DATA_W),
    .FRAC_W (FRAC_W),
    .N_FFT  (N_FFT),
    .HALF   (HALF)
  ) u_table (
    .k   (k_s),
    .inv (inv_q_r),
    .w_r (tw_r_s),
    .w_i (tw_i_s)
  );

  // Fill/phase/drain counters and per-frame inverse flag; a frame ends at the last drain step.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fill_cnt_r  <= {FW{1'b0}};
      p_r         <= {PW{1'b0}};
      drain_cnt_r <= {KW{1'b0}};
      inv_q_r     <= 1'b0;
    end else if (step_s) begin
      if (fill_cnt_r == {FW{1'b0}}) begin
        inv_q_r <= bus.inv;
      end
      if (last_drain_s) begin
        fill_cnt_r  <= {FW{1'b0}};
        p_r         <= {PW{1'b0}};
        drain_cnt_r <= {KW{1'b0}};
      end else begin
        if (fill_cnt_r < HALF_F) begin
          fill_cnt_r <= fill_cnt_r + FW'(1'b1);
        end else begin
          p_r <= p_r + PW'(1'b1);
        end
        if (draining_s) begin
          drain_cnt_r <= drain_cnt_r + KW'(1'b1);
        end else begin
          drain_cnt_r <= {KW{1'b0}};
        end
      end
    end
  end

  // Output registers; values hold across stalls while out_valid drops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_r <= 1'b0;
      out_last_r  <= 1'b0;
      w_r_r       <= W_ONE;
      w_i_r       <= {DATA_W{1'b0}};
      state_r     <= ST_FILL;
    end else begin
      out_valid_r <= step_s;
      out_last_r  <= step_s & last_drain_s;
      if (step_s) begin
        state_r <= cur_state_s;
        if (cur_state_s == ST_TWID) begin
          w_r_r <= tw_r_s;
          w_i_r <= tw_i_s;
        end else begin
          w_r_r <= W_ONE;
          w_i_r <= {DATA_W{1'b0}};
        end
      end
    end
  end

  assign bus.in_ready  = in_ready_s;
  assign bus.out_valid = out_valid_r;
  assign bus.out_last  = out_last_r;
  assign bus.w_r       = w_r_r;
  assign bus.w_i       = w_i_r;
  assign bus.state     = state_r;

  initial begin : g_param_chk
  end

endmodule

// File: tb/tb_twiddle_stream_gen.sv
// Directed bench: default stage (N_FFT=16, HALF=8) plus an N_FFT=32, HALF=4 instance.
module tb_twiddle_stream_gen;

  logic clk;
  logic rst;
  int   n_total;
  int   n_pass;
  int   n_fail;

  localparam int WR_TAB [8] = '{256, 237, 181, 98, 0, -98, -181, -237};
  localparam int WI_TAB [8] = '{0, -98, -181, -237, -256, -237, -181, -98};
  localparam int WR_TAB2 [4] = '{256, 181, 0, -181};
  localparam int WI_TAB2 [4] = '{0, -181, -256, -181};

  twiddle_stream_gen_if #(.DATA_W(24)) bus  ();
  twiddle_stream_gen_if #(.DATA_W(24)) bus2 ();

  twiddle_stream_gen #(.DATA_W(24), .FRAC_W(8), .N_FFT(16), .HALF(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  twiddle_stream_gen #(.DATA_W(24), .FRAC_W(8), .N_FFT(32), .HALF(4)) dut2 (
    .clk (clk),
    .rst (rst),
    .bus (bus2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input longint obs, input longint exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step(input logic v, input logic l, input logic i);
    bus.in_valid  = v;
    bus.in_last   = l;
    bus.inv       = i;
    bus2.in_valid = v;
    bus2.in_last  = l;
    bus2.inv      = i;
    @(posedge clk);
    #1;
  endtask

  task automatic rst_pulse();
    step(1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic chk_w(input string tag, input int st, input int wr, input int wi, input bit last);
    chk({tag, "_valid"}, bus.out_valid, 1);
    chk({tag, "_state"}, bus.state, st);
    chk({tag, "_wr"}, bus.w_r, wr);
    chk({tag, "_wi"}, bus.w_i, wi);
    chk({tag, "_last"}, bus.out_last, last);
  endtask

  // Expected output for sample n (1-based) of an uninterrupted frame.
  task automatic exp_main(input string tag, input int n, input bit inv_on, input bit last);
    if (n <= 8) begin
      chk_w(tag, 0, 256, 0, last);
    end else if (n <= 16) begin
      chk_w(tag, 1, 256, 0, last);
    end else begin
      chk_w(tag, 2, WR_TAB[n-17], inv_on ? -WI_TAB[n-17] : WI_TAB[n-17], last);
    end
  endtask

  initial begin
    n_total = 0;
    n_pass  = 0;
    n_fail  = 0;
    rst = 1'b1;
    bus.in_valid = 1'b0;  bus.in_last = 1'b0;  bus.inv = 1'b0;
    bus2.in_valid = 1'b0; bus2.in_last = 1'b0; bus2.inv = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", bus.out_valid, 0);
    chk("rst_last", bus.out_last, 0);
    chk("rst_ready", bus.in_ready, 1);
    chk("rst_state", bus.state, 0);
    chk("rst_wr", bus.w_r, 256);
    chk("rst_wi", bus.w_i, 0);
    @(negedge clk);
    rst = 1'b0;

    // Forward frame, with a 3-cycle stall before sample 12.
    for (int n = 1; n <= 24; n++) begin
      if (n == 12) begin
        for (int s = 0; s < 3; s++) begin
          step(1'b0, 1'b0, 1'b0);
          chk($sformatf("stall%0d_valid", s), bus.out_valid, 0);
          chk($sformatf("stall%0d_state", s), bus.state, 1);
          chk($sformatf("stall%0d_ready", s), bus.in_ready, 1);
        end
      end
      step(1'b1, 1'b0, 1'b0);
      exp_main($sformatf("fwd%0d", n), n, 1'b0, 1'b0);
      if (n == 18) begin
        chk("fwd18_wi_hex", longint'($unsigned(bus.w_i)), 64'h0000_0000_00FF_FF9E);
      end
    end

    // Inverse frame; inv drops mid-frame and must be ignored.
    rst_pulse();
    for (int n = 1; n <= 24; n++) begin
      step(1'b1, 1'b0, (n < 10) ? 1'b1 : 1'b0);
      exp_main($sformatf("inv%0d", n), n, 1'b1, 1'b0);
    end

    // Drain after in_last on sample 20; in_valid stays high but is refused.
    rst_pulse();
    for (int n = 1; n <= 20; n++) begin
      step(1'b1, (n == 20) ? 1'b1 : 1'b0, 1'b0);
      exp_main($sformatf("drn%0d", n), n, 1'b0, 1'b0);
    end
    for (int d = 1; d <= 8; d++) begin
      chk($sformatf("drain%0d_ready", d), bus.in_ready, 0);
      step(1'b1, 1'b0, 1'b0);
      if (d <= 4) begin
        chk_w($sformatf("drain%0d", d), 2, WR_TAB[d+3], WI_TAB[d+3], 1'b0);
      end else begin
        chk_w($sformatf("drain%0d", d), 1, 256, 0, d == 8);
      end
    end
    chk("post_drain_ready", bus.in_ready, 1);
    step(1'b1, 1'b0, 1'b0);
    chk_w("new_frame", 0, 256, 0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    chk("new_frame_idle_last", bus.out_last, 0);

    // Asynchronous reset during TWID k=3.
    rst_pulse();
    for (int n = 1; n <= 20; n++) begin
      step(1'b1, 1'b0, 1'b0);
    end
    chk_w("pre_rst", 2, 98, -237, 1'b0);
    rst = 1'b1;
    #1;
    chk("mid_rst_valid", bus.out_valid, 0);
    chk("mid_rst_state", bus.state, 0);
    chk("mid_rst_wr", bus.w_r, 256);
    chk("mid_rst_wi", bus.w_i, 0);
    @(negedge clk);
    rst = 1'b0;
    step(1'b1, 1'b0, 1'b0);
    chk_w("after_rst", 0, 256, 0, 1'b0);

    // N_FFT=32, HALF=4 instance: STRIDE=4.
    rst_pulse();
    for (int n = 1; n <= 12; n++) begin
      step(1'b1, 1'b0, 1'b0);
      chk($sformatf("p32_%0d_valid", n), bus2.out_valid, 1);
      if (n <= 4) begin
        chk($sformatf("p32_%0d_state", n), bus2.state, 0);
        chk($sformatf("p32_%0d_wr", n), bus2.w_r, 256);
      end else if (n <= 8) begin
        chk($sformatf("p32_%0d_state", n), bus2.state, 1);
        chk($sformatf("p32_%0d_wr", n), bus2.w_r, 256);
      end else begin
        chk($sformatf("p32_%0d_state", n), bus2.state, 2);
        chk($sformatf("p32_%0d_wr", n), bus2.w_r, WR_TAB2[n-9]);
        chk($sformatf("p32_%0d_wi", n), bus2.w_i, WI_TAB2[n-9]);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
